// File: rtl/mc_ctrl_pkg.sv
// mc_ctrl_pkg: shared states, opcodes, select encodings and ALU opcodes for the multi-cycle controller
package mc_ctrl_pkg;
  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE, S_EXER,
    S_EXEI, S_ALUWB, S_BRANCH, S_JAL, S_JALR, S_LUI, S_AUIPC
  } state_e;
  typedef enum logic [1:0] {CLS_ADD, CLS_R, CLS_I, CLS_BR} alu_cls_e;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [3:0] ALU_OPCODE_ADD  = 4'd0;
  localparam logic [3:0] ALU_OPCODE_SUB  = 4'd1;
  localparam logic [3:0] ALU_OPCODE_SLL  = 4'd2;
  localparam logic [3:0] ALU_OPCODE_SLT  = 4'd3;
  localparam logic [3:0] ALU_OPCODE_SLTU = 4'd4;
  localparam logic [3:0] ALU_OPCODE_XOR  = 4'd5;
  localparam logic [3:0] ALU_OPCODE_SRL  = 4'd6;
  localparam logic [3:0] ALU_OPCODE_SRA  = 4'd7;
  localparam logic [3:0] ALU_OPCODE_OR   = 4'd8;
  localparam logic [3:0] ALU_OPCODE_AND  = 4'd9;
  localparam logic [1:0] SRC_A_PC = 2'b00, SRC_A_OLDPC = 2'b01, SRC_A_RS1 = 2'b10, SRC_A_ZERO = 2'b11;
  localparam logic [1:0] SRC_B_RS2 = 2'b00, SRC_B_IMM = 2'b01, SRC_B_FOUR = 2'b10;
  localparam logic [1:0] RES_ALUOUT = 2'b00, RES_MEM = 2'b01, RES_ALU = 2'b10;
  localparam logic [2:0] IMM_I = 3'b000, IMM_S = 3'b001, IMM_B = 3'b010, IMM_U = 3'b011, IMM_J = 3'b100;
  typedef struct packed {
    logic       pc_write;
    logic       ir_write;
    logic       adr_src;
    logic       mem_write;
    logic       reg_write;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] imm_src;
    logic [1:0] result_src;
    logic       illegal;
    logic       instr_done;
  } ctrl_t;
  function automatic logic [2:0] imm_fmt(input logic [6:0] op);
    return op == OP_STORE ? IMM_S : op == OP_BRANCH ? IMM_B :
           (op == OP_LUI || op == OP_AUIPC) ? IMM_U : op == OP_JAL ? IMM_J : IMM_I;
  endfunction
endpackage

// File: rtl/multicycle_controller_alu_decoder.sv
// alu_decoder: maps the state's ALU class plus funct3/funct7[5] to an ALU opcode
module alu_decoder
  import mc_ctrl_pkg::*;
(
  input  logic [1:0] cls,
  input  logic [2:0] funct3,
  input  logic       funct7_5,
  output logic [3:0] alu_ctrl
);
  logic       alt;
  logic [3:0] arith;
  always_comb begin
    alt = funct7_5 && (cls == CLS_R || funct3 == 3'b101);
    case (funct3)
      3'b000:  arith = alt ? ALU_OPCODE_SUB : ALU_OPCODE_ADD;
      3'b001:  arith = ALU_OPCODE_SLL;
      3'b010:  arith = ALU_OPCODE_SLT;
      3'b011:  arith = ALU_OPCODE_SLTU;
      3'b100:  arith = ALU_OPCODE_XOR;
      3'b101:  arith = alt ? ALU_OPCODE_SRA : ALU_OPCODE_SRL;
      3'b110:  arith = ALU_OPCODE_OR;
      3'b111:  arith = ALU_OPCODE_AND;
      default: arith = ALU_OPCODE_ADD;
    endcase
    alu_ctrl = cls == CLS_BR  ? (funct3[2:1] == 2'b00 ? ALU_OPCODE_SUB : ALU_OPCODE_SLT) :
               cls == CLS_ADD ? ALU_OPCODE_ADD : arith;
  end
endmodule

// File: rtl/multicycle_controller.sv
// multicycle_controller: Moore FSM sequencing the multi-cycle RV32I datapath.
// Define MEM_WAIT_EN to add the mem_ready handshake that stalls FETCH, MEMREAD and MEMWRITE.
module multicycle_controller
  import mc_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] instr,
  input  logic        zero,
`ifdef MEM_WAIT_EN
  input  logic        mem_ready,
`endif
  output logic        pc_write,
  output logic        ir_write,
  output logic        adr_src,
  output logic        mem_write,
  output logic        reg_write,
  output logic [1:0]  alu_src_a,
  output logic [1:0]  alu_src_b,
  output logic [3:0]  alu_ctrl,
  output logic [2:0]  imm_src,
  output logic [1:0]  result_src,
  output logic        illegal,
  output logic        instr_done
);
  state_e     state_q, state_d;
  ctrl_t      c;
  logic [1:0] cls;
  logic [3:0] alu_dec;
  logic       rdy;
  logic [6:0] opcode;
  logic       unused_instr;
`ifdef MEM_WAIT_EN
  assign rdy = mem_ready;
`else
  assign rdy = 1'b1;
`endif
  assign opcode = instr[6:0];
  assign unused_instr = ^{instr[31], instr[29:15], instr[11:7]};
  always_ff @(posedge clk) state_q <= rst ? S_FETCH : state_d;
  always_comb begin
    c = '0;
    cls = CLS_ADD;
    state_d = state_q;
    case (state_q)
      S_FETCH: begin
        c.ir_write = rdy;
        c.pc_write = rdy;
        c.alu_src_b = SRC_B_FOUR;
        c.result_src = RES_ALU;
        state_d = rdy ? S_DECODE : S_FETCH;
      end
      S_DECODE: begin
        c.alu_src_a = SRC_A_OLDPC;
        c.alu_src_b = SRC_B_IMM;
        c.imm_src = imm_fmt(opcode);
        case (opcode)
          OP_LOAD, OP_STORE: state_d = S_MEMADR;
          OP_R:              state_d = S_EXER;
          OP_I:              state_d = S_EXEI;
          OP_BRANCH:         state_d = S_BRANCH;
          OP_JAL:            state_d = S_JAL;
          OP_JALR:           state_d = S_JALR;
          OP_LUI:            state_d = S_LUI;
          OP_AUIPC:          state_d = S_AUIPC;
          default: begin
            c.illegal = 1'b1;
            c.instr_done = 1'b1;
            state_d = S_FETCH;
          end
        endcase
      end
      S_MEMADR: begin
        c.alu_src_a = SRC_A_RS1;
        c.alu_src_b = SRC_B_IMM;
        c.imm_src = imm_fmt(opcode);
        state_d = opcode == OP_STORE ? S_MEMWRITE : S_MEMREAD;
      end
      S_MEMREAD: begin
        c.adr_src = 1'b1;
        state_d = rdy ? S_MEMWB : S_MEMREAD;
      end
      S_MEMWB: begin
        c.result_src = RES_MEM;
        c.reg_write = 1'b1;
        c.instr_done = 1'b1;
        state_d = S_FETCH;
      end
      S_MEMWRITE: begin
        c.adr_src = 1'b1;
        c.mem_write = 1'b1;
        c.instr_done = rdy;
        state_d = rdy ? S_FETCH : S_MEMWRITE;
      end
      S_EXER: begin
        c.alu_src_a = SRC_A_RS1;
        cls = CLS_R;
        state_d = S_ALUWB;
      end
      S_EXEI: begin
        c.alu_src_a = SRC_A_RS1;
        c.alu_src_b = SRC_B_IMM;
        c.imm_src = IMM_I;
        cls = CLS_I;
        state_d = S_ALUWB;
      end
      S_ALUWB: begin
        c.reg_write = 1'b1;
        c.instr_done = 1'b1;
        state_d = S_FETCH;
      end
      S_BRANCH: begin
        c.alu_src_a = SRC_A_RS1;
        cls = CLS_BR;
        c.pc_write = (instr[12] && (instr[14] || !instr[13])) ? !zero : zero;
        c.instr_done = 1'b1;
        state_d = S_FETCH;
      end
      // JAL also finishes JALR: ALUOut already holds the jump target from DECODE or JALR
      S_JAL: begin
        c.alu_src_a = SRC_A_OLDPC;
        c.alu_src_b = SRC_B_FOUR;
        c.pc_write = 1'b1;
        state_d = S_ALUWB;
      end
      S_JALR: begin
        c.alu_src_a = SRC_A_RS1;
        c.alu_src_b = SRC_B_IMM;
        c.imm_src = IMM_I;
        state_d = S_JAL;
      end
      S_LUI: begin
        c.alu_src_a = SRC_A_ZERO;
        c.alu_src_b = SRC_B_IMM;
        c.imm_src = IMM_U;
        state_d = S_ALUWB;
      end
      S_AUIPC: begin
        c.alu_src_a = SRC_A_OLDPC;
        c.alu_src_b = SRC_B_IMM;
        c.imm_src = IMM_U;
        state_d = S_ALUWB;
      end
      default: state_d = S_FETCH;
    endcase
  end
  alu_decoder u_alu_decoder (
    .cls      (cls),
    .funct3   (instr[14:12]),
    .funct7_5 (instr[30]),
    .alu_ctrl (alu_dec)
  );
  assign {pc_write, ir_write, adr_src, mem_write, reg_write, alu_src_a, alu_src_b,
          imm_src, result_src, illegal, instr_done} = rst ? '0 : c;
  assign alu_ctrl = rst ? 4'd0 : alu_dec;
endmodule

// File: doc/multicycle_controller.md
# multicycle_controller

Sequencing controller for the multi-cycle RV32I datapath: a Moore-style FSM that steps each instruction through fetch, decode, execute, memory and writeback over 3–5 cycles. It drives every enable and mux select of the shared datapath: PC, instruction register, single ALU, unified memory port and register file. It replaces the single-cycle `control_unit` decode path. Per-state control values are a pure function of the state, plus `zero`/`instr` where stated.

## Interface
- No parameters.
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  synchronous, active-high reset.
- `instr`  in  32  IR output; stable from DECODE until instruction end.
- `zero`  in  1  ALU zero/compare flag, same-cycle.
- `mem_ready`  in  1  memory handshake; present only with `MEM_WAIT_EN`.
- `pc_write`  out  1  PC register enable.
- `ir_write`  out  1  IR and old-PC register enable.
- `adr_src`  out  1  memory address select: 0 = PC, 1 = ALUOut.
- `mem_write`  out  1  memory write enable.
- `reg_write`  out  1  register-file write enable.
- `alu_src_a`  out  2  ALU A select: 00 = PC, 01 = oldPC, 10 = rs1, 11 = zero.
- `alu_src_b`  out  2  ALU B select: 00 = rs2, 01 = imm, 10 = constant 4.
- `alu_ctrl`  out  4  ALU opcode, `ALU_OPCODE_*` encoding.
- `imm_src`  out  3  immediate format: 000 = I, 001 = S, 010 = B, 011 = U, 100 = J.
- `result_src`  out  2  result bus select: 00 = ALUOut, 01 = mem data, 10 = ALU result.
- `illegal`  out  1  one-cycle pulse for an unsupported opcode.
- `instr_done`  out  1  high in the final cycle of each instruction.

## Operation
- **FETCH:** `adr_src`=0, `ir_write`=1, A=PC, B=4, ADD, `result_src`=10, `pc_write`=1. Next state is DECODE.
- **DECODE:** A=oldPC, B=imm, ADD; this latches the branch/jal target into ALUOut. `imm_src` follows the opcode. Next state by opcode:
  - load/store → MEMADR
  - 0110011 → EXER
  - 0010011 → EXEI
  - 1100011 → BRANCH
  - 1101111 → JAL
  - 1100111 → JALR
  - 0110111 → LUI
  - 0010111 → AUIPC
  - anything else → FETCH, with `illegal`=1 and `instr_done`=1.
- **MEMADR:** A=rs1, B=imm, ADD. Next state is MEMREAD for a load, MEMWRITE for a store.
- **MEMREAD:** `adr_src`=1. Next state is MEMWB.
- **MEMWB:** `result_src`=01, `reg_write`=1, done. Next state is FETCH.
- **MEMWRITE:** `adr_src`=1, `mem_write`=1, done. Next state is FETCH.
- **EXER:** A=rs1, B=rs2, `alu_ctrl` decoded from funct3/funct7[5]. Next state is ALUWB.
- **EXEI:** A=rs1, B=imm, `alu_ctrl` decoded from funct3, using funct7[5] only when funct3=101. Next state is ALUWB.
- **ALUWB:** `result_src`=00, `reg_write`=1, done. Next state is FETCH.
- **BRANCH:** A=rs1, B=rs2.
  - `alu_ctrl`: SUB for funct3 000/001, SLT otherwise.
  - `take` = `neg` ? !`zero` : `zero`, where `neg` = funct3 ∈ {001, 101, 111}.
  - `pc_write`=`take`, `result_src`=00, done. Next state is FETCH.
- **JAL:** A=oldPC, B=4, ADD, `result_src`=00, `pc_write`=1. Next state is ALUWB, which writes the link PC+4.
- **JALR:** A=rs1, B=imm, ADD. Next state is JAL.
- **LUI:** A=zero, B=imm(U), ADD. Next state is ALUWB.
- **AUIPC:** A=oldPC, B=imm(U), ADD. Next state is ALUWB.
- Every output not listed for a state is 0.
- Unused funct3 in EXER/EXEI yields ADD; the instruction still writes back.

## Timing
- **Cycles per instruction:** R/I-ALU 4, load 5, store 4, branch 3, jal 4, jalr 5, lui/auipc 4, illegal 2.
- **Reset:** while `rst` is high, all outputs are 0. On the first edge with `rst` high, state becomes FETCH.
- **Reset mid-instruction:** abandons the instruction with no further writes; the next edge gives FETCH.
- **Output sourcing:** all outputs are combinational from the state register and inputs. No output depends on `zero` except `pc_write` in BRANCH.
- **Instruction boundary:** `instr_done` and the final write occur in the same cycle; FETCH follows on the next edge.

## Configuration
- **`MEM_WAIT_EN` defined:** `mem_ready` port exists.
  - FETCH, MEMREAD and MEMWRITE hold their state while `mem_ready`=0.
  - During the hold, FETCH keeps `ir_write`/`pc_write` at 0, and MEMWRITE keeps `mem_write`=1.
  - Enables and the transition occur in the cycle `mem_ready`=1. If `mem_ready`=1 on arrival, behaviour is identical to the undefined case.
  - MEMWRITE sets `instr_done` only in the cycle it leaves.
- **`MEM_WAIT_EN` undefined:** no `mem_ready` port; memory is single-cycle and never stalls.

## Structure
- **Shared package `mc_ctrl_pkg`:**
  - state enum
  - opcode constants
  - A/B/result/imm select encodings
- **ALU opcodes:** taken from the existing shared `ALU_OPCODE_*` definitions.
- **Sub-module `alu_decoder`:** combinational; maps state class (add / R / I / branch) plus funct3/funct7[5] to `alu_ctrl`.

## Test plan
- **Reset and `addi x1,x0,5`:** hold `rst` 2 cycles, then release.
  - Outputs are 0 during reset.
  - Sequence FETCH→DECODE→EXEI→ALUWB.
  - `reg_write`=1 only in cycle 4, with `instr_done`=1.
- **`lw` (0x00012083):** 5 cycles.
  - `adr_src`=1 in cycle 4.
  - `result_src`=01 with `reg_write` in cycle 5.
- **Stores under `MEM_WAIT_EN`:** `sw` with `mem_ready` low for 3 cycles in MEMWRITE.
  - `mem_write` is held 4 cycles.
  - `instr_done` asserts once.
- **Branches:**
  - `bne` with `zero`=0 gives `pc_write`=1 in cycle 3.
  - `beq` with `zero`=0 gives `pc_write`=0.
  - `bge` sends `alu_ctrl`=`ALU_OPCODE_SLT`.
- **`jalr x1,0(x2)`:** sequence DECODE→JALR→JAL→ALUWB.
  - `pc_write` in the JAL state.
  - `reg_write` in cycle 5.
- **Illegal opcode and mid-instruction reset:**
  - Opcode 0x7F: `illegal` pulse in cycle 2, then back to FETCH.
  - `rst` during MEMREAD gives no `reg_write` and FETCH after release.
